instr_fetch_unit: RTL

//  - Fetch stage of the KLP32 core: owns the PC, issues word reads to instruction memory, buffers responses.
//  - Presents {instr, pc, imm_sel} to decode via valid/ready; id_imm_sel is predecoded from the opcode.
//  - id_imm_sel drives the immediate generator's select input directly.
//  - Accepts PC redirects (branch/jump) from execute and flushes all wrong-path instructions.

---
 rtl/klp32_pkg.sv | 57 +++++
 rtl/fetch_fifo.sv | 84 ++++++++
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/klp32_pkg.sv
// ============================================================================
// Module : klp32_pkg
// Brief  : Shared KLP32 front-end definitions: immediate-select encodings,
//          base opcodes, the canonical NOP, the fetch entry record and the
//          opcode -> immediate-select predecoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package klp32_pkg;

  // Immediate generator select; also consumed by the decoder.
  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_U    = 3'b011,
    IMM_J    = 3'b100,
    IMM_NONE = 3'b111
  } imm_sel_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // One buffered instruction as presented to decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    imm_sel_e    imm_sel;
  } fetch_entry_t;

  function automatic imm_sel_e predecode_imm_sel(input logic [6:0] opc);
    imm_sel_e sel;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: sel = IMM_I;
      OPC_STORE:                                  sel = IMM_S;
      OPC_BRANCH:                                 sel = IMM_B;
      OPC_LUI, OPC_AUIPC:                         sel = IMM_U;
      OPC_JAL:                                    sel = IMM_J;
      default:                                    sel = IMM_NONE;
    endcase
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Brief  : Small synchronous FIFO with synchronous flush, occupancy count and
//          full/empty flags. A push is accepted while full if a pop happens
//          in the same cycle (full-throughput operation).
// Ports  : clk, rst (async, active-high), flush_i, push_i, wdata_i, pop_i,
//          rdata_o (head, valid when !empty_o), count_o, full_o, empty_o
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2      // power of 2, >= 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             do_push,  do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of 2, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed when count_q > 0.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Brief  : KLP32 fetch stage. Owns the PC, issues word reads to instruction
//          memory, buffers in-order responses and hands {instr, pc, imm_sel}
//          to decode over valid/ready. Execute redirects flush the wrong path
//          and drop responses still in flight.
// Ports  : clk, rst (async, active-high)
//          imem_req_valid/ready/addr   fetch request channel
//          imem_rsp_valid/data         in-order read responses
//          redirect_valid/pc           branch/jump target from execute
//          id_valid/ready/instr/pc/imm_sel  decode interface
//          stall_cycles                present only with IF_PERF_CNT_EN
// Config : define IF_PERF_CNT_EN to add the saturating stall_cycles counter
//          (cycles with id_ready=1 and id_valid=0).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
  import klp32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2      // power of 2, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [2:0]  id_imm_sel
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int          CW    = $clog2(BUF_DEPTH) + 1;
  localparam int          EW    = $bits(fetch_entry_t);
  localparam logic [CW:0] LIMIT = (CW+1)'(BUF_DEPTH);

  logic [31:0]   pc_q,    pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q,  drop_d;

  logic          req_fire, rsp_keep, id_fire;
  logic [CW:0]   inflight;
  logic [31:0]   aq_head;
  logic [CW-1:0] aq_count, if_count;
  logic          aq_full, aq_empty, if_full, if_empty;
  fetch_entry_t  ent_in, ent_out;
  logic [EW-1:0] ent_out_raw;

  // Requests plus buffered instructions never exceed BUF_DEPTH, so every
  // response always has a FIFO slot waiting for it.
  assign inflight       = {1'b0, outst_q} + {1'b0, if_count};
  assign imem_req_valid = !rst && !redirect_valid && (inflight < LIMIT);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response is kept only if it is not owed to a dropped (wrong-path)
  // request and no redirect is flushing this cycle.
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign id_fire  = id_valid && id_ready;

  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      pc_d   = {redirect_pc[31:2], 2'b00};
      // Everything still outstanding after this cycle is wrong-path.
      drop_d = outst_d;
    end else begin
      if (req_fire) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // Addresses of issued requests, matched in order against responses.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (BUF_DEPTH)
  ) u_addr_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (rsp_keep),
    .rdata_o (aq_head),
    .count_o (aq_count),
    .full_o  (aq_full),
    .empty_o (aq_empty)
  );

  assign ent_in = '{instr:   imem_rsp_data,
                    pc:      aq_head,
                    imm_sel: predecode_imm_sel(imem_rsp_data[6:0])};

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (rsp_keep),
    .wdata_i (ent_in),
    .pop_i   (id_fire),
    .rdata_o (ent_out_raw),
    .count_o (if_count),
    .full_o  (if_full),
    .empty_o (if_empty)
  );

  assign ent_out    = fetch_entry_t'(ent_out_raw);
  assign id_valid   = !if_empty;
  assign id_instr   = if_empty ? NOP_INSTR : ent_out.instr;
  assign id_pc      = if_empty ? 32'h0000_0000 : ent_out.pc;
  assign id_imm_sel = if_empty ? IMM_NONE : ent_out.imm_sel;

  // Flags reported by the FIFOs that this block does not need.
  logic w_unused_flags;
  assign w_unused_flags = &{1'b0, aq_full, aq_empty, aq_count, if_full};

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (id_ready && !id_valid && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

`default_nettype wire
